mc_controller: RTL and testbench

MC_CONTROLLER -- requirements
Module: mc_controller

---
 rtl/mc_ctrl_pkg.sv | 42 ++++
 rtl/mc_controller_decode.sv | 48 ++++
 rtl/mc_controller.sv | 126 ++++++++++++
 tb/tb_mc_controller.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// mc_ctrl_pkg: opcode/funct constants, state and class enums, select encodings
package mc_ctrl_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] F_SRAV   = 6'h07;
  localparam logic [5:0] F_JR     = 6'h08;
  localparam logic [5:0] F_ADDU   = 6'h21;
  localparam logic [5:0] F_SUBU   = 6'h23;
  localparam logic [5:0] F_SLT    = 6'h2A;
  localparam logic [1:0] PC_PLUS4 = 2'b00;
  localparam logic [1:0] PC_JUMP  = 2'b01;
  localparam logic [1:0] PC_JR    = 2'b10;
  localparam logic [1:0] RD_RT    = 2'b00;
  localparam logic [1:0] RD_RD    = 2'b01;
  localparam logic [1:0] RD_RA    = 2'b11;
  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_PC   = 2'b10;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT} state_e;
  typedef enum logic [2:0] {C_ALU, C_ADDI, C_LW, C_SW, C_BEQ, C_J, C_JAL, C_JR} iclass_e;
  typedef struct packed {
    logic [1:0] reg_dst;
    logic       alu_src;
    logic [1:0] mem_to_reg;
    logic [1:0] ext_op;
    logic [1:0] alu_ctr;
    logic [1:0] alu_sel;
    logic       addi_sel;
  } ctrl_t;
  function automatic ctrl_t ctl(logic [1:0] rd, logic src, logic [1:0] m2r, logic [1:0] ext,
                                logic [1:0] alu, logic [1:0] asel, logic addi);
    ctl = '{rd, src, m2r, ext, alu, asel, addi};
  endfunction
endpackage

// File: rtl/mc_controller_decode.sv
// mc_decode: combinational instruction decode table with class and legality
module mc_decode
  import mc_ctrl_pkg::*;
(
  input  logic [5:0] opcode_i,
  input  logic [5:0] funct_i,
  output ctrl_t      ctrl_o,
  output iclass_e    class_o,
  output logic       legal_o
);
  always_comb begin
    ctrl_o  = '0;
    class_o = C_ALU;
    legal_o = 1'b1;
    case (opcode_i)
      OP_RTYPE: case (funct_i)
        F_ADDU:  ctrl_o = ctl(RD_RD, 1'b0, M2R_ALU, 2'b00, 2'b00, 2'b00, 1'b0);
        F_SUBU:  ctrl_o = ctl(RD_RD, 1'b0, M2R_ALU, 2'b00, 2'b01, 2'b00, 1'b0);
        F_SLT:   ctrl_o = ctl(RD_RD, 1'b0, M2R_ALU, 2'b00, 2'b01, 2'b10, 1'b0);
        F_SRAV:  ctrl_o = ctl(RD_RD, 1'b0, M2R_ALU, 2'b00, 2'b11, 2'b00, 1'b0);
        F_JR:    class_o = C_JR;
        default: legal_o = 1'b0;
      endcase
      OP_ORI:   ctrl_o = ctl(RD_RT, 1'b1, M2R_ALU, 2'b00, 2'b10, 2'b00, 1'b0);
      OP_LUI:   ctrl_o = ctl(RD_RT, 1'b1, M2R_ALU, 2'b10, 2'b10, 2'b00, 1'b0);
      OP_ADDIU: ctrl_o = ctl(RD_RT, 1'b1, M2R_ALU, 2'b01, 2'b00, 2'b00, 1'b0);
      OP_ADDI: begin
        ctrl_o  = ctl(RD_RT, 1'b1, M2R_ALU, 2'b01, 2'b00, 2'b01, 1'b1);
        class_o = C_ADDI;
      end
      OP_LW: begin
        ctrl_o  = ctl(RD_RT, 1'b1, M2R_MEM, 2'b01, 2'b00, 2'b00, 1'b0);
        class_o = C_LW;
      end
      OP_SW: begin
        ctrl_o  = ctl(RD_RT, 1'b1, M2R_ALU, 2'b01, 2'b00, 2'b00, 1'b0);
        class_o = C_SW;
      end
      OP_BEQ: begin
        ctrl_o  = ctl(RD_RT, 1'b0, M2R_ALU, 2'b00, 2'b01, 2'b00, 1'b0);
        class_o = C_BEQ;
      end
      OP_J:     class_o = C_J;
      OP_JAL:   class_o = C_JAL;
      default:  legal_o = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_controller.sv
// mc_controller: multi-cycle MIPS-subset control FSM with memory wait/timeout counter
module mc_controller
  import mc_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       ovf,
  input  logic       mem_rdy,
  output logic       mem_req,
  output logic       PCWr,
  output logic       IRWr,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] RegDst,
  output logic       ALUSrc,
  output logic [1:0] MemtoReg,
  output logic       nPC_sel,
  output logic [1:0] Ext_Op,
  output logic [1:0] ALUctr,
  output logic [1:0] pc_sel,
  output logic [1:0] alu_sel,
  output logic       addi_sel,
  output logic       illegal,
  output logic       timeout,
  output logic [2:0] state
);
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               illegal_q, illegal_d, timeout_q, timeout_d;
  ctrl_t              dec;
  iclass_e            cls;
  logic               legal, wait_hit;
  mc_decode u_dec (
    .opcode_i(opcode),
    .funct_i (funct),
    .ctrl_o  (dec),
    .class_o (cls),
    .legal_o (legal)
  );
  assign wait_hit = !mem_rdy && (cnt_q == CNT_W'(MEM_TIMEOUT - 1));
  assign state    = rst ? 3'd0 : state_q;
  assign illegal  = illegal_q & ~rst;
  assign timeout  = timeout_q & ~rst;
  always_comb begin
    state_d   = state_q;
    cnt_d     = '0;
    illegal_d = illegal_q;
    timeout_d = timeout_q;
    {mem_req, PCWr, IRWr, RegWrite, MemWrite, nPC_sel, pc_sel} = '0;
    {RegDst, ALUSrc, MemtoReg, Ext_Op, ALUctr, alu_sel, addi_sel} =
      (state_q inside {S_DECODE, S_EXEC, S_MEM, S_WB}) ? dec : '0;
    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_rdy) begin
          IRWr    = 1'b1;
          PCWr    = 1'b1;
          pc_sel  = PC_PLUS4;
          state_d = S_DECODE;
        end else if (wait_hit) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_DECODE: begin
        state_d = S_EXEC;
        if (!legal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else if (cls inside {C_J, C_JAL, C_JR}) begin
          PCWr    = 1'b1;
          pc_sel  = (cls == C_JR) ? PC_JR : PC_JUMP;
          state_d = S_FETCH;
          if (cls == C_JAL) begin
            RegWrite = 1'b1;
            RegDst   = RD_RA;
            MemtoReg = M2R_PC;
          end
        end
      end
      S_EXEC: begin
        nPC_sel = (cls == C_BEQ);
        PCWr    = (cls == C_BEQ) & zero;
        state_d = (cls == C_BEQ) ? S_FETCH : (cls inside {C_LW, C_SW}) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req  = 1'b1;
        MemWrite = (cls == C_SW);
        if (mem_rdy) state_d = (cls == C_SW) ? S_FETCH : S_WB;
        else if (wait_hit) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else cnt_d = cnt_q + CNT_W'(1);
      end
      S_WB: begin
        RegWrite = (cls == C_ADDI) ? ~ovf : 1'b1;
        state_d  = S_FETCH;
      end
      S_HALT: state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase
    if (rst) begin
      {mem_req, PCWr, IRWr, RegWrite, MemWrite, nPC_sel, pc_sel} = '0;
      {RegDst, ALUSrc, MemtoReg, Ext_Op, ALUctr, alu_sel, addi_sel} = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cnt_q     <= '0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
    end
  end
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: directed self-checking bench for mc_controller (MEM_TIMEOUT=4)
module tb_mc_controller;
  logic       clk = 1'b0, rst = 1'b1;
  logic [5:0] opcode = '0, funct = '0;
  logic       zero = 1'b0, ovf = 1'b0, mem_rdy = 1'b0;
  logic       mem_req, PCWr, IRWr, RegWrite, MemWrite, ALUSrc, nPC_sel, addi_sel, illegal, timeout;
  logic [1:0] RegDst, MemtoReg, Ext_Op, ALUctr, pc_sel, alu_sel;
  logic [2:0] state;
  int         n_cmp = 0, n_bad = 0;
  mc_controller #(.MEM_TIMEOUT(4), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero), .ovf(ovf),
    .mem_rdy(mem_rdy), .mem_req(mem_req), .PCWr(PCWr), .IRWr(IRWr), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .RegDst(RegDst), .ALUSrc(ALUSrc), .MemtoReg(MemtoReg),
    .nPC_sel(nPC_sel), .Ext_Op(Ext_Op), .ALUctr(ALUctr), .pc_sel(pc_sel), .alu_sel(alu_sel),
    .addi_sel(addi_sel), .illegal(illegal), .timeout(timeout), .state(state)
  );
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    tick;
    chk("rst_state", {5'd0, state}, 8'd0);
    chk("rst_memreq", {7'd0, mem_req}, 8'd0);
    mem_rdy = 1'b1;
    #1;
    chk("rst_strobes", {4'd0, PCWr, IRWr, RegWrite, MemWrite}, 8'd0);
    chk("rst_flags", {6'd0, illegal, timeout}, 8'd0);
    tick;
    rst = 1'b0;
    #1;
    chk("post_rst_memreq", {7'd0, mem_req}, 8'd1);
    // addu: 0,1,2,4,0
    opcode = 6'h00; funct = 6'h21;
    #1;
    chk("addu_F", {state, IRWr, PCWr, pc_sel, RegWrite}, {3'd0, 1'b1, 1'b1, 2'b00, 1'b0});
    chk("addu_F_sel", {6'd0, RegDst}, 8'd0);
    tick;
    chk("addu_D", {state, RegWrite, RegDst, 2'b00}, {3'd1, 1'b0, 2'b01, 2'b00});
    tick;
    chk("addu_E", {state, RegWrite, PCWr, 3'b000}, {3'd2, 1'b0, 1'b0, 3'b000});
    tick;
    chk("addu_WB", {state, RegWrite, RegDst, ALUctr}, {3'd4, 1'b1, 2'b01, 2'b00});
    tick;
    chk("addu_back", {5'd0, state}, 8'd0);
    // lw with three wait cycles in MEM (last completes on final permitted cycle)
    opcode = 6'h23;
    tick;
    chk("lw_D", {state, MemtoReg, Ext_Op, ALUSrc}, {3'd1, 2'b01, 2'b01, 1'b1});
    tick;
    mem_rdy = 1'b0;
    tick;
    #1;
    chk("lw_M0", {state, mem_req, MemWrite, RegWrite, 2'b00}, {3'd3, 1'b1, 1'b0, 1'b0, 2'b00});
    tick;
    tick;
    tick;
    mem_rdy = 1'b1;
    #1;
    chk("lw_M3", {state, timeout, 4'd0}, {3'd3, 1'b0, 4'd0});
    tick;
    chk("lw_WB", {state, MemtoReg, RegWrite, 2'b00}, {3'd4, 2'b01, 1'b1, 2'b00});
    tick;
    chk("lw_back", {4'd0, timeout, state}, 8'd0);
    // beq taken then not taken
    opcode = 6'h04; zero = 1'b1;
    tick;
    tick;
    chk("beq_t_E", {state, PCWr, nPC_sel, ALUctr, 1'b0}, {3'd2, 1'b1, 1'b1, 2'b01, 1'b0});
    tick;
    chk("beq_t_back", {5'd0, state}, 8'd0);
    zero = 1'b0;
    tick;
    tick;
    chk("beq_nt_E", {state, PCWr, nPC_sel, 3'b000}, {3'd2, 1'b0, 1'b1, 3'b000});
    tick;
    // addi with overflow suppresses write-back
    opcode = 6'h08; ovf = 1'b1;
    tick;
    tick;
    tick;
    chk("addi_WB", {state, RegWrite, addi_sel, alu_sel, 1'b0}, {3'd4, 1'b0, 1'b1, 2'b01, 1'b0});
    tick;
    ovf = 1'b0;
    // jal
    opcode = 6'h03;
    tick;
    chk("jal_D", {RegDst, MemtoReg, RegWrite, PCWr, pc_sel}, {2'b11, 2'b10, 1'b1, 1'b1, 2'b01});
    tick;
    chk("jal_back", {5'd0, state}, 8'd0);
    // jr
    opcode = 6'h00; funct = 6'h08;
    tick;
    chk("jr_D", {state, PCWr, pc_sel, RegWrite, 1'b0}, {3'd1, 1'b1, 2'b10, 1'b0, 1'b0});
    tick;
    chk("jr_back", {5'd0, state}, 8'd0);
    // sw completing with zero wait
    opcode = 6'h2B;
    tick;
    tick;
    tick;
    chk("sw_M", {state, MemWrite, mem_req, Ext_Op, 1'b0}, {3'd3, 1'b1, 1'b1, 2'b01, 1'b0});
    tick;
    chk("sw_back", {4'd0, MemWrite, state}, 8'd0);
    // illegal opcode halts
    opcode = 6'h3F;
    tick;
    tick;
    chk("ill_halt", {state, illegal, mem_req, PCWr, IRWr, 1'b0}, {3'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0});
    tick;
    chk("ill_stay", {state, illegal, RegWrite, MemWrite, 2'b00}, {3'd5, 1'b1, 1'b0, 1'b0, 2'b00});
    rst = 1'b1;
    tick;
    rst = 1'b0;
    #1;
    chk("ill_cleared", {4'd0, illegal, state}, 8'd0);
    // sw reset mid-access
    opcode = 6'h2B;
    tick;
    tick;
    mem_rdy = 1'b0;
    tick;
    #1;
    chk("swr_M", {state, MemWrite, 4'd0}, {3'd3, 1'b1, 4'd0});
    rst = 1'b1;
    #1;
    chk("swr_rst_cycle", {3'd0, MemWrite, mem_req, state}, 8'd0);
    tick;
    rst = 1'b0;
    #1;
    chk("swr_after", {4'd0, mem_req, state}, {4'd0, 1'b1, 3'd0});
    // timeout in FETCH after 4 idle cycles
    tick;
    tick;
    tick;
    chk("to_pre", {4'd0, timeout, state}, 8'd0);
    tick;
    chk("to_halt", {4'd0, timeout, state}, {4'd0, 1'b1, 3'd5});
    chk("to_halt_req", {7'd0, mem_req}, 8'd0);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    tick;
    tick;
    tick;
    mem_rdy = 1'b1;
    #1;
    chk("to_last_ok", {3'd0, IRWr, timeout, state}, {3'd0, 1'b1, 1'b0, 3'd0});
    tick;
    chk("to_last_dec", {4'd0, timeout, state}, {4'd0, 1'b0, 3'd1});
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
